// File: rtl/c_shift_ctrl_pkg.sv
// Shared types and helpers for the elastic shift-chain flow controller.
package c_shift_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/c_shift_ctrl_stage.sv
// One stage of the elastic chain: valid flop plus move/load-enable logic.
module c_shift_ctrl_stage (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic next_move,
   output logic valid,
   output logic move,
   output logic en
);

   assign move = ~valid | next_move;
   assign en   = move & in_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
      end else if (move) begin
         valid <= in_valid;
      end
   end

endmodule

// File: rtl/c_shift_ctrl.sv
// Flow controller for an elastic register chain with drain sequencing.
// Optional output-stall counter: define C_SHIFT_CTRL_STALL_CNT_EN.
module c_shift_ctrl
   import c_shift_ctrl_pkg::*;
#(
   parameter int depth           = 2,
   parameter int cnt_width       = clog2(depth + 1),
   parameter int stall_cnt_width = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_valid,
   output logic                       push_ready,
   output logic                       pop_valid,
   input  logic                       pop_ready,
   output logic [depth-1:0]           stage_en,
   output logic [depth-1:0]           stage_valid,
   output logic [cnt_width-1:0]       occupancy,
   input  logic                       drain_req,
   output logic                       drain_done,
   output logic                       active,
   output logic [stall_cnt_width-1:0] stall_cnt
);

   state_t               state;
   logic                 pop;
   logic                 push;
   logic                 drain_fire;
   logic [cnt_width-1:0] occ_next;

   assign pop_valid = stage_valid[depth-1];
   assign pop       = pop_valid & pop_ready;

   // Move ripples from the output side; each stage keeps its own net.
   for (genvar i = 0; i < depth; i++) begin : g_stage
      logic mv;
      logic nm;
      logic iv;

      if (i == depth - 1) begin : g_last
         assign nm = pop;
      end else begin : g_mid
         assign nm = g_stage[i+1].mv;
      end

      if (i == 0) begin : g_first
         assign iv = push;
      end else begin : g_rest
         assign iv = stage_valid[i-1];
      end

      c_shift_ctrl_stage u_stage (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (iv),
         .next_move (nm),
         .valid     (stage_valid[i]),
         .move      (mv),
         .en        (stage_en[i])
      );
   end

   assign push_ready = g_stage[0].mv & (state != DRAIN);
   assign push       = push_valid & push_ready;
   assign active     = push_valid | (|stage_valid);

   assign occ_next   = occupancy + cnt_width'(push) - cnt_width'(pop);
   assign drain_fire = (state == DRAIN) && (occ_next == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         occupancy  <= '0;
         drain_done <= 1'b0;
      end else begin
         occupancy  <= occ_next;
         drain_done <= drain_fire;
         unique case (state)
            IDLE: begin
               if (drain_req)  state <= DRAIN;
               else if (push)  state <= BUSY;
            end
            BUSY: begin
               if (drain_req)             state <= DRAIN;
               else if (occ_next == '0)   state <= IDLE;
            end
            DRAIN: begin
               if (drain_fire) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef C_SHIFT_CTRL_STALL_CNT_EN
   logic [stall_cnt_width-1:0] stall_q;

   // Saturating count of cycles the output item waits on downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (drain_fire) begin
         stall_q <= '0;
      end else if (pop_valid && !pop_ready && !(&stall_q)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_c_shift_ctrl.sv
// Self-checking bench for c_shift_ctrl: item-position model plus directed cases.
module tb_c_shift_ctrl;

   localparam int D  = 3;
   localparam int CW = 2;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push_valid = 1'b0;
   logic          pop_ready = 1'b0;
   logic          drain_req = 1'b0;
   logic          push_ready;
   logic          pop_valid;
   logic [D-1:0]  stage_en;
   logic [D-1:0]  stage_valid;
   logic [CW-1:0] occupancy;
   logic          drain_done;
   logic          active;
   logic [SW-1:0] stall_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   c_shift_ctrl #(
      .depth           (D),
      .stall_cnt_width (SW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .pop_valid   (pop_valid),
      .pop_ready   (pop_ready),
      .stage_en    (stage_en),
      .stage_valid (stage_valid),
      .occupancy   (occupancy),
      .drain_req   (drain_req),
      .drain_done  (drain_done),
      .active      (active),
      .stall_cnt   (stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of item positions, oldest first; mode 0 idle, 1 busy, 2 drain.
   int           mpos[$];
   int           np[$];
   int           mmode;
   bit           mdone;
   int           mstall;
   int           n, lim, p, occ_new;
   bit           popv, popx, prdy, pushx, done_next;
   logic [D-1:0] ev, een;
   int           exp_stall;

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_valid", stage_valid, 0);
         chk("rst_occ", occupancy, 0);
         chk("rst_pop_valid", pop_valid, 0);
         chk("rst_done", drain_done, 0);
         chk("rst_stall", stall_cnt, 0);
         mpos.delete();
         mmode = 0;
         mdone = 0;
         mstall = 0;
      end else begin
         n = mpos.size();
         ev = '0;
         foreach (mpos[k]) ev[mpos[k]] = 1'b1;
         popv = (n > 0) && (mpos[0] == D - 1);
         popx = popv && pop_ready;
         np.delete();
         een = '0;
         lim = D;
         for (int k = (popx ? 1 : 0); k < n; k++) begin
            p = mpos[k] + 1;
            if (p > lim - 1) p = lim - 1;
            if (p != mpos[k]) een[p] = 1'b1;
            np.push_back(p);
            lim = p;
         end
         prdy = (lim >= 1) && (mmode != 2);
         pushx = push_valid && prdy;
         if (pushx) begin
            een[0] = 1'b1;
            np.push_back(0);
         end
`ifdef C_SHIFT_CTRL_STALL_CNT_EN
         exp_stall = mstall;
`else
         exp_stall = 0;
`endif
         chk("stage_valid", stage_valid, ev);
         chk("pop_valid", pop_valid, popv);
         chk("push_ready", push_ready, prdy);
         chk("stage_en", stage_en, een);
         chk("occupancy", occupancy, n);
         chk("drain_done", drain_done, mdone);
         chk("active", active, push_valid || (n > 0));
         chk("stall_cnt", stall_cnt, exp_stall);

         occ_new = np.size();
         done_next = (mmode == 2) && (occ_new == 0);
         if (mmode != 2 && drain_req) mmode = 2;
         else if (mmode == 0 && pushx) mmode = 1;
         else if (occ_new == 0) mmode = 0;
         mdone = done_next;
         if (done_next) mstall = 0;
         else if (popv && !pop_ready && mstall < (1 << SW) - 1) mstall++;
         mpos = np;
      end
   end

   task automatic cyc(input logic pv, input logic pr, input logic dr);
      @(posedge clk);
      #1;
      push_valid = pv;
      pop_ready  = pr;
      drain_req  = dr;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_sat;
`ifdef C_SHIFT_CTRL_STALL_CNT_EN
      exp_sat = (1 << SW) - 1;
`else
      exp_sat = 0;
`endif
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;

      // stream with pop_ready held high
      cyc(1, 1, 0); chk("s0_en", stage_en, 3'b001); chk("s0_rdy", push_ready, 1);
      cyc(1, 1, 0); chk("s1_en", stage_en, 3'b011);
      cyc(1, 1, 0); chk("s2_en", stage_en, 3'b111); chk("s2_pv", pop_valid, 0);
      cyc(1, 1, 0); chk("s3_pv", pop_valid, 1); chk("s3_occ", occupancy, 3);
      chk("s3_en", stage_en, 3'b111);
      cyc(0, 1, 0); chk("s4_en", stage_en, 3'b110); chk("s4_pv", pop_valid, 1);
      cyc(0, 1, 0); chk("s5_en", stage_en, 3'b100); chk("s5_occ", occupancy, 2);
      cyc(0, 1, 0); chk("s6_en", stage_en, 3'b000); chk("s6_pv", pop_valid, 1);
      cyc(0, 1, 0); chk("s7_pv", pop_valid, 0); chk("s7_occ", occupancy, 0);

      // full stall, then simultaneous pop and push
      repeat (3) cyc(1, 0, 0);
      cyc(1, 0, 0); chk("fs_rdy", push_ready, 0); chk("fs_en", stage_en, 3'b000);
      chk("fs_occ", occupancy, 3);
      cyc(1, 1, 0); chk("fp_rdy", push_ready, 1); chk("fp_en", stage_en, 3'b111);
      cyc(0, 0, 0); chk("fp_occ", occupancy, 3); chk("fp_sv", stage_valid, 3'b111);

      // long output stall saturates the counter
      repeat (20) cyc(1, 0, 0);
      chk("stall_sat", stall_cnt, exp_sat);

      // drain a full pipe with push_valid held
      cyc(1, 0, 1); chk("dr_rdy0", push_ready, 0);
      cyc(1, 1, 0); chk("dr_rdy1", push_ready, 0);
      cyc(1, 1, 0);
      cyc(1, 1, 0); chk("dr_done_early", drain_done, 0); chk("dr_occ1", occupancy, 1);
      cyc(0, 0, 0); chk("dr_done", drain_done, 1); chk("dr_occ0", occupancy, 0);
      chk("dr_rdy_idle", push_ready, 1); chk("dr_stall_clr", stall_cnt, 0);
      cyc(0, 0, 0); chk("dr_done_once", drain_done, 0);

      // drain of an empty pipe
      cyc(0, 0, 1);
      cyc(1, 0, 0); chk("de_rdy", push_ready, 0); chk("de_done0", drain_done, 0);
      cyc(0, 0, 0); chk("de_done", drain_done, 1); chk("de_rdy_idle", push_ready, 1);
      cyc(0, 0, 0); chk("de_done_once", drain_done, 0);

      // bubble collapse while stalled
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0); chk("bb_sv0", stage_valid, 3'b101); chk("bb_occ", occupancy, 2);
      chk("bb_rdy0", push_ready, 1);
      cyc(0, 0, 0); chk("bb_sv1", stage_valid, 3'b110); chk("bb_rdy1", push_ready, 1);
      chk("bb_en", stage_en, 3'b000);
      cyc(0, 1, 0);
      cyc(0, 1, 0);
      cyc(0, 1, 0); chk("bb_flush", occupancy, 0);

      // asynchronous reset mid-flight
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0); chk("rm_occ", occupancy, 2);
      reset = 1'b0;
      #1;
      chk("rm_sv", stage_valid, 0); chk("rm_occ0", occupancy, 0);
      chk("rm_pv", pop_valid, 0);
      cyc(0, 0, 0); chk("rm_done0", drain_done, 0);
      cyc(0, 0, 0); chk("rm_done1", drain_done, 0);
      #1 reset = 1'b1;
      cyc(0, 0, 0); chk("rm_done2", drain_done, 0); chk("rm_sv_after", stage_valid, 0);

      // randomized traffic against the model
      for (int blk = 0; blk < 30; blk++) begin
         int pv_w, pr_w;
         pv_w = $urandom_range(1, 4);
         pr_w = $urandom_range(0, 4);
         for (int c = 0; c < 100; c++) begin
            cyc($urandom_range(0, 4) < pv_w,
                $urandom_range(0, 3) < pr_w,
                $urandom_range(0, 40) == 0);
         end
      end
      repeat (8) cyc(0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/c_shift_ctrl.md
Name: c_shift_ctrl

Overview:
- Flow controller for an elastic chain of `depth` registered stages of `width` bits each. Stage 0 is the input side; stage `depth-1` is the output side.
- Tracks per-stage valid bits and produces a per-stage load enable. Stalls propagate backward with bubble collapsing.
- Provides a push/pop valid-ready handshake and a drain sequence for quiescing the pipe before reconfiguration or power-down.
- Also drives the datapath `active` hint used for clock gating.

Parameters:
- depth, 2, number of pipeline stages (≥1).
- cnt_width, clog2(depth+1), occupancy counter width.
- stall_cnt_width, 16, width of the optional stall counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- push_valid  input  1  upstream item available.
- push_ready  output  1  controller accepts the item this cycle.
- pop_valid  output  1  output stage holds a valid item.
- pop_ready  input  1  downstream consumes the item this cycle.
- stage_en  output  depth  per-stage load enable for the datapath registers.
- stage_valid  output  depth  registered per-stage valid bits.
- occupancy  output  cnt_width  number of valid stages.
- drain_req  input  1  single-cycle request to drain the pipe.
- drain_done  output  1  one-cycle pulse when the drain completes.
- active  output  1  datapath activity hint (clock-gate enable).
- stall_cnt  output  stall_cnt_width  output-stall cycle count (optional feature).

Behaviour:
- Reset (asynchronous assert, synchronous release): stage_valid=0, occupancy=0, state=IDLE, drain_done=0, stall_cnt=0.
- Pop and move chain:
  - pop = pop_valid & pop_ready; pop_valid = stage_valid[depth-1].
  - move[depth-1] = pop | ~stage_valid[depth-1].
  - move[i] = ~stage_valid[i] | move[i+1] for i < depth-1. This is combinational and ripples from the output side.
- Push: push_ready = move[0] & (state != DRAIN); push = push_valid & push_ready.
- Incoming valid: in[0] = push; in[i] = stage_valid[i-1].
- Load enable: stage_en[i] = move[i] & in[i]. stage_en is 0 on any bubble or stall.
- Valid update: stage_valid[i] <= move[i] ? in[i] : stage_valid[i].
- Latency: an item pushed in cycle t into an empty pipe shows pop_valid at t+depth.
- Throughput: 1 item/cycle when pop_ready is held high.
- Full pipe: all valid and pop_ready=0 gives push_ready=0. Full pipe with pop=1 gives push_ready=1 in the same cycle, with no bubble.
- Bubbles: a bubble collapses one stage per cycle while the output is stalled.
- Occupancy: occupancy <= occupancy + push - pop. Simultaneous push and pop leaves it unchanged. It never exceeds depth and never underflows.
- State machine (registered state):
  - IDLE (occupancy 0) → BUSY when push.
  - BUSY → IDLE when next occupancy = 0.
  - IDLE/BUSY → DRAIN when drain_req. A push in the same cycle is still accepted, because push_ready uses the current state.
  - DRAIN: push_ready=0 and drain_req is ignored. The state goes to IDLE when next occupancy = 0.
  - drain_done is registered and equals 1 exactly in the first cycle after the DRAIN→IDLE transition. drain_req in IDLE with an empty pipe gives DRAIN for one cycle, then drain_done.
- active = push_valid | (|stage_valid) (combinational).
- Reset asserted mid-operation drops all items immediately. No drain_done pulse is generated.

Optional Feature:
- Macro: C_SHIFT_CTRL_STALL_CNT_EN.
- Defined: stall_cnt increments every cycle where pop_valid & ~pop_ready. It saturates at all-ones and does not wrap. It clears to 0 on reset and on the cycle drain_done is asserted.
- Undefined: no counter register exists and stall_cnt is tied to 0. All other behaviour is identical.

Decomposition:
- Package c_shift_ctrl_pkg holds:
  - typedef state_t enum {IDLE, BUSY, DRAIN};
  - a clog2 function for cnt_width.
- Sub-module c_shift_ctrl_stage holds one stage's valid flop and its move/enable logic, instantiated depth times in a generate loop. The top level owns the FSM, occupancy, drain and stall logic.

Test Plan:
- Stream, depth=3, pop_ready=1, push 4 items on consecutive cycles → pop_valid first at cycle 3, then 4 consecutive pops; occupancy peaks at 3; stage_en pattern shifts diagonally.
- Full stall, depth=3: fill with 3 items, hold pop_ready=0 → push_ready=0 and stage_en=000. Raise pop_ready with push_valid=1 → pop and push occur in the same cycle; occupancy stays 3.
- Bubble collapse, depth=4: push, skip one cycle, push, with pop_ready=0 → items compact to stages 3 and 2; occupancy=2; push_ready stays 1.
- Drain, depth=2: 2 items in the pipe, drain_req pulse with push_valid=1 (occupancy 2, so no push is accepted) → push_ready=0 while in DRAIN. After 2 pops, occupancy=0, then exactly one drain_done cycle; state is IDLE and push_ready=1.
- Reset mid-flight: occupancy 2, assert reset asynchronously between clock edges → stage_valid=0, occupancy=0 and pop_valid=0 immediately; no drain_done.
- Stall counter (macro defined), stall_cnt_width=4: hold pop_valid=1, pop_ready=0 for 20 cycles → stall_cnt saturates at 15. Drain → stall_cnt=0. Macro undefined → stall_cnt stays 0 throughout.
